// File: rtl/ddbb32_enum_if.sv
// Configuration-space access bus: one outstanding request, held until ack_i (master = enumerator).
interface ddbb32_enum_if;
  logic        cs_config_o;
  logic        we_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i;

  modport master (
    output cs_config_o, we_o, sel_o, adr_o, dat_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  cs_config_o, we_o, sel_o, adr_o, dat_o,
    output dat_i, ack_i
  );
endinterface

// File: rtl/ddbb32_enum.sv
// Bus enumerator: scans slots, sizes BAR0..2, assigns aligned windows and enables devices; waits on ack_i per access.
// Build with DDBB32_ENUM_TIMEOUT_EN to end unacknowledged accesses after TIMEOUT cycles.
module ddbb32_enum #(
  parameter logic [3:0]  CFG_SPACE = 4'hD,
  parameter logic [7:0]  CFG_BUS   = 8'd0,
  parameter logic [5:0]  MAX_DEV   = 6'd32,
  parameter logic [31:0] MEM_BASE  = 32'h4000_0000,
  parameter logic [31:0] MEM_LIMIT = 32'h7FFF_FFFF,
  parameter logic [5:0]  CMD_REG   = 6'd1,
  parameter logic [7:0]  TIMEOUT   = 8'd255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [5:0]    dev_count_o,
  output logic [31:0]   next_adr_o,
  ddbb32_enum_if.master cfg
);

  typedef enum logic [2:0] {
    IDLE, RD_ID, SZ_WR, SZ_RD, AS_WR, CMD_WR, NEXT, DONE
  } state_t;

  state_t      state_q, state_n;
  logic [5:0]  slot_q, slot_n;
  logic [1:0]  bar_q, bar_n;
  logic [32:0] ptr_q, ptr_n;
  logic [32:0] size_q, size_n;
  logic [5:0]  cnt_q, cnt_n;
  logic        err_q, err_n;
  logic        busy_q, busy_n;
  logic        done_q, done_n;
  logic        cs_q, cs_n;
  logic        we_q, we_n;
  logic [3:0]  sel_q, sel_n;
  logic [31:0] adr_q, adr_n;
  logic [31:0] dat_q, dat_n;

  logic        issue;
  logic        issue_we;
  logic [5:0]  issue_reg;
  logic [31:0] issue_dat;

  logic        tmo_hit;
  logic        acc_done;
  logic [31:0] rdat;
  logic [31:0] sz_mask;
  logic [5:0]  bar_reg;
  logic [32:0] size_m1;
  logic [32:0] base;
  logic [33:0] last;
  logic        ovf;

`ifdef DDBB32_ENUM_TIMEOUT_EN
  logic [7:0] tmo_q;

  // An ack arriving on the final cycle still wins over the watchdog.
  assign tmo_hit = cs_q && !cfg.ack_i && (tmo_q >= (TIMEOUT - 8'd1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_q <= 8'd0;
    end else if (!cs_q || cfg.ack_i || tmo_hit) begin
      tmo_q <= 8'd0;
    end else begin
      tmo_q <= tmo_q + 8'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;

  // TIMEOUT only shapes the watchdog; without it an access waits for ack_i forever.
  if (TIMEOUT == 8'd0) begin : g_no_watchdog
  end
`endif

  assign acc_done = cs_q && (cfg.ack_i || tmo_hit);
  assign rdat     = tmo_hit ? 32'hFFFF_FFFF : cfg.dat_i;
  assign sz_mask  = rdat & 32'hFFFF_FFF0;
  assign bar_reg  = 6'd4 + {4'd0, bar_q};

  // Natural alignment of the window; 'last' is one bit wider so the limit compare cannot wrap.
  assign size_m1  = size_q - 33'd1;
  assign base     = (ptr_q + size_m1) & ~size_m1;
  assign last     = {1'b0, base} + {1'b0, size_m1};
  assign ovf      = last > {2'b00, MEM_LIMIT};

  always_comb begin
    state_n   = state_q;
    slot_n    = slot_q;
    bar_n     = bar_q;
    ptr_n     = ptr_q;
    size_n    = size_q;
    cnt_n     = cnt_q;
    err_n     = err_q;
    cs_n      = cs_q;
    we_n      = we_q;
    sel_n     = sel_q;
    adr_n     = adr_q;
    dat_n     = dat_q;
    issue     = 1'b0;
    issue_we  = 1'b0;
    issue_reg = 6'd0;
    issue_dat = 32'd0;

    // Dropping cs on completion gives the mandatory idle cycle before the next state issues.
    if (acc_done) begin
      cs_n  = 1'b0;
      we_n  = 1'b0;
      sel_n = 4'h0;
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_n = RD_ID;
          slot_n  = 6'd0;
          ptr_n   = {1'b0, MEM_BASE};
          cnt_n   = 6'd0;
          err_n   = 1'b0;
        end
      end

      RD_ID: begin
        if (!cs_q) begin
          issue     = 1'b1;
          issue_reg = 6'd0;
        end else if (acc_done) begin
          if (rdat[15:0] == 16'hFFFF) begin
            state_n = NEXT;
          end else begin
            cnt_n   = cnt_q + 6'd1;
            bar_n   = 2'd0;
            state_n = SZ_WR;
          end
        end
      end

      SZ_WR: begin
        if (!cs_q) begin
          issue     = 1'b1;
          issue_we  = 1'b1;
          issue_reg = bar_reg;
          issue_dat = 32'hFFFF_FFFF;
        end else if (acc_done) begin
          state_n = SZ_RD;
        end
      end

      SZ_RD: begin
        if (!cs_q) begin
          issue     = 1'b1;
          issue_reg = bar_reg;
        end else if (acc_done) begin
          if (sz_mask == 32'd0) begin
            if (bar_q == 2'd2) begin
              state_n = CMD_WR;
            end else begin
              bar_n   = bar_q + 2'd1;
              state_n = SZ_WR;
            end
          end else begin
            size_n  = {1'b0, (~sz_mask) + 32'd1};
            state_n = AS_WR;
          end
        end
      end

      AS_WR: begin
        if (!cs_q) begin
          issue     = 1'b1;
          issue_we  = 1'b1;
          issue_reg = bar_reg;
          issue_dat = ovf ? 32'd0 : base[31:0];
        end else if (acc_done) begin
          if (ovf) begin
            err_n = 1'b1;
          end else begin
            ptr_n = base + size_q;
          end
          if (bar_q == 2'd2) begin
            state_n = CMD_WR;
          end else begin
            bar_n   = bar_q + 2'd1;
            state_n = SZ_WR;
          end
        end
      end

      CMD_WR: begin
        if (!cs_q) begin
          issue     = 1'b1;
          issue_we  = 1'b1;
          issue_reg = CMD_REG;
          issue_dat = 32'h0000_0006;
        end else if (acc_done) begin
          state_n = NEXT;
        end
      end

      NEXT: begin
        if (slot_q == (MAX_DEV - 6'd1)) begin
          state_n = DONE;
        end else begin
          slot_n  = slot_q + 6'd1;
          state_n = RD_ID;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    if (issue) begin
      cs_n  = 1'b1;
      we_n  = issue_we;
      sel_n = 4'hF;
      adr_n = {CFG_SPACE, CFG_BUS, slot_q[4:0], 7'd0, issue_reg, 2'b00};
      dat_n = issue_dat;
    end

    busy_n = (state_n != IDLE) && (state_n != DONE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      slot_q  <= 6'd0;
      bar_q   <= 2'd0;
      ptr_q   <= 33'd0;
      size_q  <= 33'd0;
      cnt_q   <= 6'd0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_n;
      slot_q  <= slot_n;
      bar_q   <= bar_n;
      ptr_q   <= ptr_n;
      size_q  <= size_n;
      cnt_q   <= cnt_n;
      err_q   <= err_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      cs_q    <= cs_n;
      we_q    <= we_n;
      sel_q   <= sel_n;
      adr_q   <= adr_n;
      dat_q   <= dat_n;
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign dev_count_o     = cnt_q;
  assign next_adr_o      = ptr_q[31:0];
  assign cfg.cs_config_o = cs_q;
  assign cfg.we_o        = we_q;
  assign cfg.sel_o       = sel_q;
  assign cfg.adr_o       = adr_q;
  assign cfg.dat_o       = dat_q;

endmodule

// File: tb/tb_ddbb32_enum.sv
// Directed bench for ddbb32_enum: config-space device model plus write scoreboard on two DUT builds.
`timescale 1ns/1ps
module tb_ddbb32_enum;

  localparam logic [7:0] TMO = 8'd4;
`ifdef DDBB32_ENUM_TIMEOUT_EN
  localparam int SLOW = 2;
`else
  localparam int SLOW = 7;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_a, start_b;
  logic        busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [5:0]  cnt_a, cnt_b;
  logic [31:0] next_a, next_b;

  ddbb32_enum_if bif_a ();
  ddbb32_enum_if bif_b ();

  ddbb32_enum #(.TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
    .err_o(err_a), .dev_count_o(cnt_a), .next_adr_o(next_a), .cfg(bif_a)
  );

  ddbb32_enum #(.MEM_LIMIT(32'h4000_0FFF), .TIMEOUT(TMO)) dut_lim (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
    .err_o(err_b), .dev_count_o(cnt_b), .next_adr_o(next_b), .cfg(bif_b)
  );

  always #5 clk_i = ~clk_i;

  // device model configuration (written by the stimulus only)
  logic        present [32];
  logic [15:0] vid [32];
  logic [31:0] mask [32][3];
  bit          use_b = 1'b0;
  bit          silent = 1'b0;
  int          delay = 0;

  // responder-owned state
  logic [31:0] barv [32][3];
  logic        resp_ack = 1'b0;
  logic [31:0] resp_dat = 32'd0;
  int          viol = 0;
  logic [42:0] wr_q [$];

  logic [42:0] sb_q [$];
  int          n_chk = 0;
  int          n_fail = 0;

  assign bif_a.ack_i = resp_ack && !use_b;
  assign bif_b.ack_i = resp_ack && use_b;
  assign bif_a.dat_i = resp_dat;
  assign bif_b.dat_i = resp_dat;

  always @(negedge clk_i) begin : responder
    logic        cs, we, in_acc;
    logic [3:0]  sel;
    logic [31:0] adr, wd, l_adr, l_dat;
    logic        l_we;
    logic [4:0]  s;
    logic [5:0]  r;
    int          cnt, bi;
    cs  = use_b ? bif_b.cs_config_o : bif_a.cs_config_o;
    we  = use_b ? bif_b.we_o : bif_a.we_o;
    sel = use_b ? bif_b.sel_o : bif_a.sel_o;
    adr = use_b ? bif_b.adr_o : bif_a.adr_o;
    wd  = use_b ? bif_b.dat_o : bif_a.dat_o;
    if (cs !== 1'b1) begin
      resp_ack = 1'b0;
      in_acc   = 1'b0;
      cnt      = 0;
    end else if (resp_ack) begin
      viol++;                       // request still up the cycle after its ack
      resp_ack = 1'b0;
    end else begin
      if (!in_acc) begin
        in_acc = 1'b1;
        cnt    = 0;
        l_adr  = adr;
        l_dat  = wd;
        l_we   = we;
        if (sel != 4'hF || adr[31:28] != 4'hD || adr[27:20] != 8'd0 ||
            adr[14:8] != 7'd0 || adr[1:0] != 2'd0) viol++;
      end else if (adr != l_adr || wd != l_dat || we != l_we || sel != 4'hF) begin
        viol++;
      end
      if (!silent && cnt >= delay) begin
        resp_ack = 1'b1;
        s  = adr[19:15];
        r  = adr[7:2];
        bi = int'(r) - 4;
        if (we) begin
          if (bi >= 0 && bi <= 2) barv[s][bi] = wd & mask[s][bi];
          if (!(bi >= 0 && bi <= 2 && wd == 32'hFFFF_FFFF)) wr_q.push_back({s, r, wd});
        end else if (r == 6'd0) begin
          resp_dat = present[s] ? {16'h0000, vid[s]} : 32'hFFFF_FFFF;
        end else if (bi >= 0 && bi <= 2) begin
          resp_dat = barv[s][bi];
        end else begin
          resp_dat = 32'd0;
        end
      end else begin
        cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    logic [42:0] obs, exp;
    while (wr_q.size() != 0) begin
      obs = wr_q.pop_front();
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : {43{1'b1}};
      chk("cfg_write", {21'd0, obs}, {21'd0, exp});
    end
  endtask

  task automatic clear_devs();
    for (int i = 0; i < 32; i++) begin
      present[i] = 1'b0;
      vid[i]     = 16'hFFFF;
      for (int j = 0; j < 3; j++) mask[i][j] = 32'd0;
    end
    sb_q.delete();
  endtask

  task automatic add_dev(input int s, input logic [15:0] v,
                         input logic [31:0] m0, input logic [31:0] m1, input logic [31:0] m2);
    present[s] = 1'b1;
    vid[s]     = v;
    mask[s][0] = m0;
    mask[s][1] = m1;
    mask[s][2] = m2;
  endtask

  task automatic exp_wr(input int s, input int r, input logic [31:0] d);
    logic [4:0] s5;
    logic [5:0] r6;
    s5 = s[4:0];
    r6 = r[5:0];
    sb_q.push_back({s5, r6, d});
  endtask

  task automatic pulse_start(input bit b);
    use_b = b;
    @(negedge clk_i);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk_i);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic run_scan(input string tag, input bit b, input logic [5:0] e_cnt,
                          input logic [31:0] e_next, input logic e_err);
    bit got;
    int v0;
    v0 = viol;
    pulse_start(b);
    chk({tag, "_busy"}, b ? busy_b : busy_a, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk_i);
      drain();
      if ((b ? done_b : done_a) === 1'b1) got = 1'b1;
    end
    chk({tag, "_done_seen"}, got, 1'b1);
    chk({tag, "_dev_count"}, b ? cnt_b : cnt_a, e_cnt);
    chk({tag, "_next_adr"}, b ? next_b : next_a, e_next);
    chk({tag, "_err"}, b ? err_b : err_a, e_err);
    chk({tag, "_busy_at_done"}, b ? busy_b : busy_a, 1'b0);
    @(negedge clk_i);
    drain();
    chk({tag, "_done_pulse"}, b ? done_b : done_a, 1'b0);
    chk({tag, "_sb_left"}, sb_q.size(), 0);
    chk({tag, "_bus_protocol"}, viol - v0, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    rst_i   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    clear_devs();
    repeat (3) @(negedge clk_i);

    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_err", err_a, 1'b0);
    chk("rst_count", cnt_a, 6'd0);
    chk("rst_next", next_a, 32'd0);
    chk("rst_cs", bif_a.cs_config_o, 1'b0);
    chk("rst_we", bif_a.we_o, 1'b0);
    chk("rst_sel", bif_a.sel_o, 4'h0);
    chk("rst_adr", bif_a.adr_o, 32'd0);
    chk("rst_dat", bif_a.dat_o, 32'd0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("idle_no_access", bif_a.cs_config_o, 1'b0);

    // single responder at slot 3
    add_dev(3, 16'h1234, 32'hFFFF_F000, 32'd0, 32'd0);
    exp_wr(3, 4, 32'h4000_0000);
    exp_wr(3, 1, 32'h0000_0006);
    run_scan("one_dev", 1'b0, 6'd1, 32'h4000_1000, 1'b0);

    // same scan with slow acks
    delay = SLOW;
    exp_wr(3, 4, 32'h4000_0000);
    exp_wr(3, 1, 32'h0000_0006);
    run_scan("slow_ack", 1'b0, 6'd1, 32'h4000_1000, 1'b0);
    delay = 0;

    // two devices, second window aligned up to its size
    clear_devs();
    add_dev(1, 16'h0A0A, 32'hFFFF_FF00, 32'd0, 32'd0);
    add_dev(5, 16'h0B0B, 32'hFFFF_0000, 32'd0, 32'd0);
    exp_wr(1, 4, 32'h4000_0000);
    exp_wr(1, 1, 32'h0000_0006);
    exp_wr(5, 4, 32'h4001_0000);
    exp_wr(5, 1, 32'h0000_0006);
    run_scan("two_dev", 1'b0, 6'd2, 32'h4002_0000, 1'b0);

    // 2 GB BAR after a small one overflows; pointer untouched for the next device
    clear_devs();
    add_dev(0, 16'h0001, 32'hFFFF_FF00, 32'h8000_0000, 32'd0);
    add_dev(7, 16'h0007, 32'hFFFF_F000, 32'd0, 32'd0);
    exp_wr(0, 4, 32'h4000_0000);
    exp_wr(0, 5, 32'h0000_0000);
    exp_wr(0, 1, 32'h0000_0006);
    exp_wr(7, 4, 32'h4000_1000);
    exp_wr(7, 1, 32'h0000_0006);
    run_scan("big_bar", 1'b0, 6'd2, 32'h4000_2000, 1'b1);

    // tight window: first BAR fills it exactly, second overflows
    clear_devs();
    add_dev(0, 16'h00C0, 32'hFFFF_F000, 32'd0, 32'd0);
    add_dev(2, 16'h00C2, 32'hFFFF_F000, 32'd0, 32'd0);
    exp_wr(0, 4, 32'h4000_0000);
    exp_wr(0, 1, 32'h0000_0006);
    exp_wr(2, 4, 32'h0000_0000);
    exp_wr(2, 1, 32'h0000_0006);
    run_scan("limit", 1'b1, 6'd2, 32'h4000_1000, 1'b1);

    // reset while a BAR sizing read is outstanding, then rescan
    clear_devs();
    add_dev(0, 16'hABCD, 32'hFFFF_F000, 32'd0, 32'd0);
    delay = SLOW;
    pulse_start(1'b0);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (bif_a.cs_config_o === 1'b1 && bif_a.we_o === 1'b0 && bif_a.adr_o[7:2] == 6'd4) got = 1'b1;
      else @(negedge clk_i);
    end
    chk("abort_reached_sz_rd", got, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("abort_cs", bif_a.cs_config_o, 1'b0);
    chk("abort_busy", busy_a, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    drain();
    delay = 0;
    exp_wr(0, 4, 32'h4000_0000);
    exp_wr(0, 1, 32'h0000_0006);
    run_scan("rescan", 1'b0, 6'd1, 32'h4000_1000, 1'b0);

    // nobody answers
    clear_devs();
    silent = 1'b1;
`ifdef DDBB32_ENUM_TIMEOUT_EN
    run_scan("timeout", 1'b0, 6'd0, 32'h4000_0000, 1'b0);
`else
    pulse_start(1'b0);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (done_a === 1'b1) got = 1'b1;
    end
    chk("stall_no_done", got, 1'b0);
    chk("stall_cs_held", bif_a.cs_config_o, 1'b1);
    chk("stall_busy", busy_a, 1'b1);
    chk("stall_adr_slot0", bif_a.adr_o, 32'hD000_0000);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
`endif
    silent = 1'b0;
    repeat (2) @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ddbb32_enum.md
DDBB32_ENUM -- requirements
Module: ddbb32_enum

Interface
REQ-001 SHALL have parameter CFG_SPACE, default 4'hD, driven on adr_o[31:28] for every config access.
REQ-002 SHALL have parameter CFG_BUS, default 8'd0, the bus number scanned (adr_o[27:20]).
REQ-003 SHALL have parameter MAX_DEV, default 6'd32, the number of device slots scanned (0..MAX_DEV-1, function 0).
REQ-004 SHALL have parameter MEM_BASE, default 32'h4000_0000, the first assignable address.
REQ-005 SHALL have parameter MEM_LIMIT, default 32'h7FFF_FFFF, the last assignable address.
REQ-006 SHALL have parameter CMD_REG, default 6'd1, the register index of the command/status word.
REQ-007 SHALL have parameter TIMEOUT, default 8'd255, the ack wait limit in cycles.
REQ-008 Ports: clk_i  in  1  clock; rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-009 Ports: start_i  in  1  begin scan (level, sampled in IDLE); busy_o  out  1  scan in progress; done_o  out  1  one-cycle completion pulse; err_o  out  1  sticky allocation overflow.
REQ-010 Ports: dev_count_o  out  6  devices found; next_adr_o  out  32  allocation pointer after scan.
REQ-011 Ports: cs_config_o  out  1  access request; we_o  out  1  write; sel_o  out  4  byte lanes; adr_o  out  32  config address; dat_o  out  32  write data; dat_i  in  32  read data; ack_i  in  1  access complete.

Function
REQ-012 Address: adr_o[31:28]=CFG_SPACE, [27:20]=CFG_BUS, [19:15]=slot, [14:12]=0, [7:2]=register index, others 0.
REQ-013 Access: cs_config_o, we_o, sel_o=4'hF, adr_o, dat_o held stable until ack_i high; dat_i captured on the ack_i cycle; cs_config_o low for at least one cycle between accesses; one access outstanding.
REQ-014 States: IDLE, RD_ID, SZ_WR, SZ_RD, AS_WR, CMD_WR, NEXT, DONE.
REQ-015 IDLE: start_i high -> RD_ID, slot=0, ptr=MEM_BASE, dev_count=0, err cleared, busy_o=1; start_i during busy ignored.
REQ-016 RD_ID: read reg 0; dat_i[15:0]==16'hFFFF -> NEXT; else dev_count+1, bar=0 -> SZ_WR.
REQ-017 SZ_WR: write 32'hFFFF_FFFF to reg 4+bar -> SZ_RD.
REQ-018 SZ_RD: read reg 4+bar; m=dat_i & 32'hFFFF_FFF0; m==0 -> BAR unimplemented, advance bar; else size=(~m)+1 -> AS_WR.
REQ-019 AS_WR: base=(ptr+size-1) & ~(size-1) in 33-bit arithmetic; base+size-1 > MEM_LIMIT -> write 0, err_o=1, ptr unchanged; else write base, ptr=base+size.
REQ-020 After bar 2 -> CMD_WR: write 32'h0000_0006 (memory space, bus master) to CMD_REG -> NEXT.
REQ-021 NEXT: slot==MAX_DEV-1 -> DONE; else slot+1 -> RD_ID.
REQ-022 DONE: done_o=1 for one cycle, busy_o=0, dev_count_o and next_adr_o hold final values -> IDLE.
REQ-023 Boundary: size 32'h8000_0000 with ptr above MEM_BASE overflows per REQ-019; ptr reaching exactly MEM_LIMIT+1 is legal, and any subsequent non-zero BAR overflows.

Reset
REQ-024 rst_i SHALL force IDLE asynchronously; cs_config_o, we_o, busy_o, done_o, err_o=0; sel_o=0; adr_o, dat_o, next_adr_o=0; dev_count_o=0; an in-flight access is abandoned, not completed.

Configuration
REQ-025 Macro DDBB32_ENUM_TIMEOUT_EN defined: an access unacked after TIMEOUT cycles ends with cs_config_o low; a read returns 32'hFFFF_FFFF, and a write is treated as complete. Undefined: waits for ack_i indefinitely, no counter logic.

Verification
REQ-026 Responder at slot 3 only (vendor 16'h1234, BAR0 mask 32'hFFFF_F000, BAR1/2 read back 0), start -> BAR0 written 32'h4000_0000, cmd 0x0006 written, dev_count_o=1, next_adr_o=32'h4000_1000, done_o pulse.
REQ-027 Two devices, BAR0 sizes 0x100 then 0x10000 -> bases 32'h4000_0000 and 32'h4001_0000, next_adr_o=32'h4002_0000.
REQ-028 MEM_LIMIT=32'h4000_0FFF, BAR sizes 0x1000 then 0x1000 -> first BAR at 32'h4000_0000, second written 0, err_o=1.
REQ-029 TIMEOUT_EN, no responders, TIMEOUT=4 -> every slot times out, dev_count_o=0, done_o after scanning 32 slots; without macro, bench stalls at slot 0 with cs_config_o held high.
REQ-030 rst_i asserted mid SZ_RD with cs_config_o high -> cs_config_o low same cycle, busy_o=0; a subsequent start_i rescans from slot 0.
REQ-031 ack_i delayed 7 cycles on every access -> adr_o/dat_o stable throughout each access, results identical to REQ-026.
